// File: rtl/riscv_define.sv
// Shared write-back definitions: source select codes,
// load size codes and the write-back stage state encoding.
package riscv_define;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_CSR = 2'b11;

  localparam logic [1:0] LD_SIZE_B = 2'b00;
  localparam logic [1:0] LD_SIZE_H = 2'b01;
  localparam logic [1:0] LD_SIZE_W = 2'b10;
  localparam logic [1:0] LD_SIZE_D = 2'b11;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_RSP = 1'b1
  } wb_state_e;

endpackage

// File: rtl/riscv_ld_align.sv
// Load lane select and sign/zero extension of a raw memory word.
// Purely combinational; shared with the store-to-load forward path.
module riscv_ld_align
  import riscv_define::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  data,
  input  logic [1:0]       size,
  input  logic             uns,
  input  logic [OFF_W-1:0] off,
  output logic [XLEN-1:0]  result
);

  logic [OFF_W-1:0] sh;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  mask;
  logic             sbit;

  always_comb begin
    sh = '0;
    unique case (1'b1)
      (size == LD_SIZE_B): sh = off;
      (size == LD_SIZE_H): sh = {off[OFF_W-1:1], 1'b0};
      (size == LD_SIZE_W): begin
        if (XLEN == 64)
          sh = {off[OFF_W-1], {(OFF_W-1){1'b0}}};
      end
      default: sh = '0;
    endcase
  end

  assign shifted = data >> {sh, 3'b000};

  // Double on a 32-bit core falls through to full width, i.e. a word.
  always_comb begin
    mask = '1;
    sbit = 1'b0;
    unique case (1'b1)
      (size == LD_SIZE_B): begin
        mask = XLEN'(8'hFF);
        sbit = shifted[7];
      end
      (size == LD_SIZE_H): begin
        mask = XLEN'(16'hFFFF);
        sbit = shifted[15];
      end
      (size == LD_SIZE_W): begin
        mask = XLEN'(32'hFFFF_FFFF);
        sbit = shifted[31];
      end
      default: begin
        mask = '1;
        sbit = 1'b0;
      end
    endcase
  end

  assign result = (shifted & mask)
                | ((sbit & ~uns) ? ~mask : '0);

endmodule

// File: rtl/riscv_wb_stage.sv
// Write-back stage: source select, load alignment, memory wait,
// register-file write port and retired-instruction counter.
module riscv_wb_stage
  import riscv_define::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int OFF_W   = $clog2(XLEN/8)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_rd_we,
  input  logic [RADDR_W-1:0] in_rd_addr,
  input  logic [1:0]         in_wb_sel,
  input  logic [XLEN-1:0]    in_alu_res,
  input  logic [XLEN-1:0]    in_pc4,
  input  logic [XLEN-1:0]    in_csr_val,
  input  logic [1:0]         in_ld_size,
  input  logic               in_ld_unsigned,
  input  logic [OFF_W-1:0]   in_byte_off,
  input  logic               mem_rsp_valid,
  input  logic [XLEN-1:0]    mem_rsp_data,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               retire,
  output logic [63:0]        instret
);

  wb_state_e state, state_nx;

  logic               h_we;
  logic [RADDR_W-1:0] h_addr;
  logic [1:0]         h_size;
  logic               h_uns;
  logic [OFF_W-1:0]   h_off;

  logic               accept;
  logic               is_mem;
  logic               capture;
  logic               do_wr;
  logic               wr_we;
  logic [RADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]    wr_data;
  logic [XLEN-1:0]    sel_data;
  logic [XLEN-1:0]    ld_data;

  logic [1:0]         a_size;
  logic               a_uns;
  logic [OFF_W-1:0]   a_off;

  assign in_ready = (state == WB_IDLE);
  assign accept   = in_valid & in_ready;
  assign is_mem   = (in_wb_sel == WB_SEL_MEM);

  // Held fields drive the aligner while a load is outstanding.
  assign a_size = (state == WB_WAIT_RSP) ? h_size : in_ld_size;
  assign a_uns  = (state == WB_WAIT_RSP) ? h_uns  : in_ld_unsigned;
  assign a_off  = (state == WB_WAIT_RSP) ? h_off  : in_byte_off;

  riscv_ld_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_ld_align (
    .data   (mem_rsp_data),
    .size   (a_size),
    .uns    (a_uns),
    .off    (a_off),
    .result (ld_data)
  );

  always_comb begin
    sel_data = in_alu_res;
    unique case (1'b1)
      (in_wb_sel == WB_SEL_ALU): sel_data = in_alu_res;
      (in_wb_sel == WB_SEL_MEM): sel_data = ld_data;
      (in_wb_sel == WB_SEL_PC4): sel_data = in_pc4;
      (in_wb_sel == WB_SEL_CSR): sel_data = in_csr_val;
      default:                   sel_data = in_alu_res;
    endcase
  end

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    do_wr    = 1'b0;
    wr_we    = in_rd_we;
    wr_addr  = in_rd_addr;
    wr_data  = sel_data;
    unique case (state)
      WB_IDLE: begin
        if (accept) begin
          if (is_mem && !mem_rsp_valid) begin
            capture  = 1'b1;
            state_nx = WB_WAIT_RSP;
          end else begin
            do_wr = 1'b1;
          end
        end
      end
      WB_WAIT_RSP: begin
        wr_we   = h_we;
        wr_addr = h_addr;
        wr_data = ld_data;
        if (mem_rsp_valid) begin
          do_wr    = 1'b1;
          state_nx = WB_IDLE;
        end
      end
      default: state_nx = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= WB_IDLE;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      retire   <= 1'b0;
      instret  <= '0;
      h_we     <= 1'b0;
      h_addr   <= '0;
      h_size   <= '0;
      h_uns    <= 1'b0;
      h_off    <= '0;
    end else begin
      state  <= state_nx;
      retire <= do_wr;
      rf_we  <= do_wr & wr_we & (wr_addr != '0);
      if (do_wr) begin
        rf_waddr <= wr_addr;
        rf_wdata <= wr_data;
        instret  <= instret + 64'd1;
      end
      if (capture) begin
        h_we   <= in_rd_we;
        h_addr <= in_rd_addr;
        h_size <= in_ld_size;
        h_uns  <= in_ld_unsigned;
        h_off  <= in_byte_off;
      end
    end
  end

endmodule

// File: tb/tb_riscv_wb_stage.sv
// Directed bench for the write-back stage on XLEN=32 and XLEN=64
// instances with hand-computed expected values.
module tb_riscv_wb_stage;
  import riscv_define::*;

  logic clk;
  logic rst_n;

  logic        in_valid, in_ready, in_rd_we;
  logic [4:0]  in_rd_addr;
  logic [1:0]  in_wb_sel, in_ld_size;
  logic [31:0] in_alu_res, in_pc4, in_csr_val;
  logic        in_ld_unsigned;
  logic [1:0]  in_byte_off;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rf_we, retire;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [63:0] instret;

  logic        v64, rdy64, we64;
  logic [4:0]  rd64;
  logic [1:0]  sel64, sz64;
  logic [63:0] alu64, pc64, csr64;
  logic        uns64;
  logic [2:0]  off64;
  logic        rv64;
  logic [63:0] rd_data64;
  logic        rfwe64, ret64;
  logic [4:0]  rfwa64;
  logic [63:0] rfwd64;
  logic [63:0] inst64;

  int checks = 0;
  int errors = 0;

  riscv_wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_we(in_rd_we), .in_rd_addr(in_rd_addr),
    .in_wb_sel(in_wb_sel), .in_alu_res(in_alu_res),
    .in_pc4(in_pc4), .in_csr_val(in_csr_val),
    .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
    .in_byte_off(in_byte_off),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire(retire), .instret(instret)
  );

  riscv_wb_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v64), .in_ready(rdy64),
    .in_rd_we(we64), .in_rd_addr(rd64),
    .in_wb_sel(sel64), .in_alu_res(alu64),
    .in_pc4(pc64), .in_csr_val(csr64),
    .in_ld_size(sz64), .in_ld_unsigned(uns64),
    .in_byte_off(off64),
    .mem_rsp_valid(rv64), .mem_rsp_data(rd_data64),
    .rf_we(rfwe64), .rf_waddr(rfwa64), .rf_wdata(rfwd64),
    .retire(ret64), .instret(inst64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd,
                       input logic [1:0] sz, input logic uns,
                       input logic [1:0] off);
    in_valid       = 1'b1;
    in_rd_we       = 1'b1;
    in_rd_addr     = rd;
    in_wb_sel      = sel;
    in_ld_size     = sz;
    in_ld_unsigned = uns;
    in_byte_off    = off;
  endtask

  task automatic ld64(input logic [1:0] sz, input logic uns,
                      input logic [2:0] off, input logic [63:0] d);
    v64       = 1'b1;
    we64      = 1'b1;
    rd64      = 5'd10;
    sel64     = WB_SEL_MEM;
    sz64      = sz;
    uns64     = uns;
    off64     = off;
    rv64      = 1'b1;
    rd_data64 = d;
    step();
    v64  = 1'b0;
    rv64 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_rd_we = 0; in_rd_addr = 0; in_wb_sel = 0;
    in_alu_res = 0; in_pc4 = 0; in_csr_val = 0;
    in_ld_size = 0; in_ld_unsigned = 0; in_byte_off = 0;
    mem_rsp_valid = 0; mem_rsp_data = 0;
    v64 = 0; we64 = 0; rd64 = 0; sel64 = 0; alu64 = 0;
    pc64 = 0; csr64 = 0; sz64 = 0; uns64 = 0; off64 = 0;
    rv64 = 0; rd_data64 = 0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_retire", 64'(retire), 64'd0);
    chk("rst_instret", instret, 64'd0);

    issue(WB_SEL_ALU, 5'd5, LD_SIZE_W, 1'b0, 2'd0);
    in_alu_res = 32'h1234;
    step();
    in_valid = 1'b0;
    chk("alu_we", 64'(rf_we), 64'd1);
    chk("alu_waddr", 64'(rf_waddr), 64'd5);
    chk("alu_wdata", 64'(rf_wdata), 64'h1234);
    chk("alu_retire", 64'(retire), 64'd1);
    chk("alu_instret", instret, 64'd1);

    issue(WB_SEL_PC4, 5'd0, LD_SIZE_W, 1'b0, 2'd0);
    in_pc4 = 32'h104;
    step();
    in_valid = 1'b0;
    chk("x0_we", 64'(rf_we), 64'd0);
    chk("x0_retire", 64'(retire), 64'd1);
    chk("x0_instret", instret, 64'd2);

    issue(WB_SEL_CSR, 5'd3, LD_SIZE_W, 1'b0, 2'd0);
    in_csr_val = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    chk("csr_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    chk("csr_waddr", 64'(rf_waddr), 64'd3);
    step();
    chk("idle_retire", 64'(retire), 64'd0);
    chk("idle_hold", 64'(rf_wdata), 64'hDEAD_BEEF);

    issue(WB_SEL_MEM, 5'd7, LD_SIZE_B, 1'b0, 2'd3);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lb_stall%0d", i), 64'(in_ready), 64'd0);
      chk($sformatf("lb_nowe%0d", i), 64'(rf_we), 64'd0);
      if (i == 2) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h80FF_FF00;
      end
      step();
    end
    mem_rsp_valid = 1'b0;
    chk("lb_we", 64'(rf_we), 64'd1);
    chk("lb_wdata", 64'(rf_wdata), 64'hFFFF_FF80);
    chk("lb_waddr", 64'(rf_waddr), 64'd7);
    chk("lb_ready", 64'(in_ready), 64'd1);
    chk("lb_instret", instret, 64'd4);
    step();
    chk("lb_once", 64'(rf_we), 64'd0);

    issue(WB_SEL_MEM, 5'd8, LD_SIZE_H, 1'b1, 2'd2);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBEEF_1234;
    step();
    mem_rsp_valid = 1'b0;
    issue(WB_SEL_ALU, 5'd9, LD_SIZE_W, 1'b0, 2'd0);
    in_alu_res = 32'hA5;
    chk("lhu_we", 64'(rf_we), 64'd1);
    chk("lhu_wdata", 64'(rf_wdata), 64'h0000_BEEF);
    chk("lhu_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("b2b_waddr", 64'(rf_waddr), 64'd9);
    chk("b2b_wdata", 64'(rf_wdata), 64'hA5);
    chk("b2b_retire", 64'(retire), 64'd1);
    chk("b2b_instret", instret, 64'd6);

    issue(WB_SEL_MEM, 5'd11, LD_SIZE_B, 1'b0, 2'd0);
    step();
    in_valid = 1'b0;
    chk("rw_stall", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_0077;
    step();
    mem_rsp_valid = 1'b0;
    chk("rw_nowe", 64'(rf_we), 64'd0);
    chk("rw_noret", 64'(retire), 64'd0);
    chk("rw_ready", 64'(in_ready), 64'd1);
    chk("rw_instret", instret, 64'd0);
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    chk("spur_we", 64'(rf_we), 64'd0);
    chk("spur_instret", instret, 64'd0);

    ld64(LD_SIZE_W, 1'b0, 3'd4, 64'h8000_0001_0000_0000);
    chk("lw64", rfwd64, 64'hFFFF_FFFF_8000_0001);
    ld64(LD_SIZE_W, 1'b1, 3'd4, 64'h8000_0001_0000_0000);
    chk("lwu64", rfwd64, 64'h0000_0000_8000_0001);
    ld64(LD_SIZE_D, 1'b0, 3'd0, 64'h8877_6655_4433_2211);
    chk("ld64", rfwd64, 64'h8877_6655_4433_2211);
    ld64(LD_SIZE_B, 1'b1, 3'd7, 64'h8877_6655_4433_2211);
    chk("lbu64", rfwd64, 64'h88);
    ld64(LD_SIZE_H, 1'b0, 3'd7, 64'h8877_6655_4433_2211);
    chk("lh64", rfwd64, 64'hFFFF_FFFF_FFFF_8877);
    chk("inst64", inst64, 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
